program_loader: RTL and testbench



---
 rtl/program_loader_pkg.sv | 28 ++
 rtl/program_loader_word_assembler.sv | 48 ++++
 rtl/program_loader.sv | 174 +++++++++++++++++
 tb/tb_program_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// ---------------------------------------------------------------------------
// processador_defs
// Shared definitions for the boot-time program loader and the instruction
// memory of Processador. This package holds the loader FSM state encoding,
// the frame geometry constants and the default instruction-memory address
// width, so that the loader and the memory agree on one value.
// No ports (package).
// ---------------------------------------------------------------------------
package processador_defs;

    // Instruction-memory word-address width. Capacity is 2^ADDR_WIDTH words.
    localparam int ADDR_WIDTH_DEFAULT = 8;

    // Frame geometry: the count prefix is 2 bytes, and every word is 4 bytes.
    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int LANE_BITS  = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHK    = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } loader_state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Collects little-endian bytes into 32-bit words. The first byte of a word
// ends up in bits 7:0. A lane counter tracks the byte position. When the
// last lane arrives, the complete word is presented combinationally
// together with word_valid, in the same cycle as that byte.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   clear         FSM-requested clear of the partial word and lane counter
//   byte_valid    byte_in is a data byte accepted this cycle
//   byte_in       data byte
//   word_valid    high when byte_in completes a word
//   word          assembled word (valid with word_valid)
// ---------------------------------------------------------------------------
module word_assembler
    import processador_defs::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int HELD_BITS = 8 * (WORD_BYTES - 1);

    logic [LANE_BITS-1:0] lane;
    logic [HELD_BITS-1:0] held;

    // Only the first three bytes need to be stored. The fourth byte is
    // merged straight into the output word, so the word is ready on the
    // same cycle that its last byte arrives.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            lane <= '0;
            held <= '0;
        end else if (byte_valid) begin
            lane <= lane + LANE_BITS'(1);
            held <= {byte_in, held[HELD_BITS-1:8]};
        end
    end

    assign word_valid = byte_valid && (lane == LANE_BITS'(WORD_BYTES - 1));
    assign word       = {byte_in, held};

endmodule

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Boot-time loader. It receives a length-prefixed, little-endian byte frame
// and writes the resulting 32-bit words to consecutive instruction-memory
// addresses, starting at 0. It holds Processador in reset until the image
// is complete.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, the frame
// carries a trailing checksum byte. The 8-bit sum of all frame bytes must
// be 0; if it is not, the load ends in the error state.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   in_data       stream byte, accepted when in_valid & in_ready
//   in_valid      in_data is valid
//   in_ready      loader accepts a byte this cycle
//   mem_we        instruction-memory write strobe (one cycle per word)
//   mem_addr      word address (held between writes)
//   mem_wdata     write data (held between writes)
//   cpu_reset     reset to Processador, released only on a successful load
//   done          load completed (sticky until reset)
//   error         load aborted (sticky until reset)
// ---------------------------------------------------------------------------
module program_loader
    import processador_defs::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    loader_state_t         state;
    loader_state_t         next_state;
    logic [7:0]            len_lo;
    logic [15:0]           word_count;
    logic [15:0]           rx_count;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  accept;
    logic                  data_byte;
    logic                  asm_clear;
    logic                  word_valid;
    logic [31:0]           word;
    logic                  last_word;

    assign accept    = in_valid && in_ready;
    assign data_byte = accept && (state == ST_DATA);
    assign asm_clear = (state != ST_DATA);
    assign rx_count  = {in_data, len_lo};

    // Compare in 17 bits so that a full memory (N = 2^ADDR_WIDTH) is
    // still detected correctly when word_idx is about to wrap.
    assign last_word = ((17'(word_idx) + 17'd1) == {1'b0, word_count});

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_next;

    assign sum_next = sum + in_data;

    // The running sum covers every accepted byte, including the
    // checksum byte itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum_next;
        end
    end
`endif

    word_assembler u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (data_byte),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_LEN_LO;
        end else begin
            state <= next_state;
        end
    end

    // in_ready is also forced low during reset, so that the reset cycle
    // itself never advertises acceptance.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            ST_LEN_LO: begin
                in_ready = !reset;
                if (accept) next_state = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                in_ready = !reset;
                if (accept) begin
                    if ({1'b0, rx_count} > MAX_WORDS) begin
                        next_state = ST_ERR;
                    end else if (rx_count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        next_state = ST_CHK;
`else
                        next_state = ST_DONE;
`endif
                    end else begin
                        next_state = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                in_ready = !reset;
                if (word_valid && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    next_state = ST_CHK;
`else
                    next_state = ST_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                in_ready = !reset;
                if (accept) next_state = (sum_next == 8'd0) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: next_state = ST_DONE;
            ST_ERR:  next_state = ST_ERR;
            default: next_state = ST_LEN_LO;
        endcase
    end

    // Frame counters and the registered memory write port. mem_addr and
    // mem_wdata change only on a write, so they hold their values between
    // writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            len_lo     <= '0;
            word_count <= '0;
            word_idx   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_we <= word_valid;
            if (word_valid) begin
                mem_addr  <= word_idx;
                mem_wdata <= word;
                word_idx  <= word_idx + ADDR_WIDTH'(1);
            end
            if (accept && (state == ST_LEN_LO)) len_lo <= in_data;
            if (accept && (state == ST_LEN_HI)) word_count <= rx_count;
        end
    end

    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERR);
    assign cpu_reset = (state != ST_DONE);

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Self-checking bench for program_loader. A frame-level model predicts the
// list of memory writes and the final status from the word list, the count
// and the checksum rule. A negedge monitor compares every mem_we pulse
// against that list. Follows LOADER_CHECKSUM_EN if it is defined.
// ---------------------------------------------------------------------------
module tb_program_loader;
    import processador_defs::*;

    localparam int AW        = ADDR_WIDTH_DEFAULT;
    localparam int MAX_WORDS = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          last;
    } exp_write_t;

    int          checks = 0;
    int          errors = 0;
    exp_write_t  exp_q[$];
    logic [7:0]  frame_q[$];
    logic [31:0] word_q[$];
    logic [31:0] held_addr;
    logic [31:0] held_data;
    bit          exp_done;
    bit          exp_error;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Every write pulse must match the next predicted write. done must be
    // raised together with the last write only when there is no checksum.
    exp_write_t mon_e;
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", 32'(mem_we), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("write_addr", 32'(mem_addr), mon_e.addr);
                checkOutput("write_data", mem_wdata, mon_e.data);
                checkOutput("done_at_write", 32'(done), 32'(mon_e.last));
                checkOutput("cpu_reset_at_write", 32'(cpu_reset), 32'(!mon_e.last));
            end
        end
    end

    // One byte offered for one cycle, optionally preceded by idle cycles
    // that carry garbage data with in_valid low.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clock); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("reset_in_ready_during", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("reset_in_ready_after", 32'(in_ready), 32'd1);
        held_addr = 0;
        held_data = 0;
        exp_q.delete();
    endtask

    // Builds the byte frame for count n from word_q. It also predicts the
    // writes, the final status and the values the write port should hold
    // afterwards. A corrupt checksum is the correct value plus one.
    task automatic prepareFrame(input int n, input bit corrupt);
        logic [7:0] sum;
        logic [7:0] chk;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        foreach (word_q[i])
            for (int b = 0; b < WORD_BYTES; b++)
                frame_q.push_back(word_q[i][8*b +: 8]);
        if (CHK_EN && n <= MAX_WORDS) begin
            sum = 8'd0;
            foreach (frame_q[i]) sum = sum + frame_q[i];
            chk = -sum;
            if (corrupt) chk = chk + 8'd1;
            frame_q.push_back(chk);
        end
        if (n > MAX_WORDS) begin
            exp_done  = 1'b0;
            exp_error = 1'b1;
        end else begin
            foreach (word_q[i])
                exp_q.push_back('{i, word_q[i], (i == n - 1) && !CHK_EN});
            if (n > 0) begin
                held_addr = 32'(n - 1);
                held_data = word_q[n-1];
            end
            exp_done  = !(CHK_EN && corrupt);
            exp_error = !exp_done;
        end
    endtask

    // gap_mode: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random
    task automatic runFrame(input int n, input bit corrupt, input int gap_mode);
        int gap;
        prepareFrame(n, corrupt);
        foreach (frame_q[i]) begin
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
            applyStimulus(frame_q[i], gap);
        end
        checkOutput("end_done", 32'(done), 32'(exp_done));
        checkOutput("end_error", 32'(error), 32'(exp_error));
        checkOutput("end_cpu_reset", 32'(cpu_reset), 32'(!exp_done));
        checkOutput("end_in_ready", 32'(in_ready), 32'd0);
        for (int j = 0; j < 3; j++) applyStimulus(8'($urandom), 0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
        checkOutput("sticky_done", 32'(done), 32'(exp_done));
        checkOutput("sticky_error", 32'(error), 32'(exp_error));
        checkOutput("held_addr", 32'(mem_addr), held_addr);
        checkOutput("held_data", mem_wdata, held_data);
    endtask

    initial begin
        int n;
        #1;
        doReset();

        $display("[TB] single word frame");
        word_q = '{32'h12345678};
        runFrame(1, 1'b0, 0);

        $display("[TB] two words with alternate idle cycles");
        doReset();
        word_q = '{$urandom, $urandom};
        runFrame(2, 1'b0, 1);

        $display("[TB] empty frame");
        doReset();
        word_q.delete();
        runFrame(0, 1'b0, 0);

        $display("[TB] oversize count 257");
        doReset();
        word_q.delete();
        runFrame(MAX_WORDS + 1, 1'b0, 0);

        $display("[TB] reset in the middle of a frame");
        doReset();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h78, 0);
        applyStimulus(8'h56, 0);
        doReset();
        word_q = '{32'h12345678};
        runFrame(1, 1'b0, 0);

        if (CHK_EN) begin
            $display("[TB] bad checksum");
            doReset();
            word_q = '{32'h12345678};
            runFrame(1, 1'b1, 0);
        end

        $display("[TB] full memory");
        doReset();
        word_q.delete();
        for (int i = 0; i < MAX_WORDS; i++) word_q.push_back($urandom);
        runFrame(MAX_WORDS, 1'b0, 2);

        $display("[TB] random frames");
        for (int k = 0; k < 10; k++) begin
            doReset();
            word_q.delete();
            if ($urandom_range(0, 4) == 0) begin
                n = MAX_WORDS + 1 + int'($urandom_range(0, 1000));
            end else begin
                n = int'($urandom_range(0, 6));
                for (int i = 0; i < n; i++) word_q.push_back($urandom);
            end
            runFrame(n, 1'($urandom_range(0, 1)), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
